// File: rtl/mem_master.sv
// Initiator-side controller for a single-port wen/ren memory with a shared tristate data bus.
// Accepts one-beat read/write requests and inserts a turnaround cycle whenever the bus direction flips.
module mem_master #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  inout  logic [DW-1:0] mem_data
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TURN  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_WR   = 2'd1;
  localparam logic [1:0] DIR_RD   = 2'd2;

  logic [1:0]    state_reg;
  logic [1:0]    last_dir_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          we_reg;
  logic [CW-1:0] cnt_reg;
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_rdata_reg;

  logic          accept;
  logic [1:0]    req_dir;

  assign req_ready = (state_reg == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign req_dir   = req_we ? DIR_WR : DIR_RD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      last_dir_reg  <= DIR_NONE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            we_reg    <= req_we;
            cnt_reg   <= '0;
            // A direction change needs one idle bus cycle so the two drivers never overlap
            if ((last_dir_reg != DIR_NONE) && (req_dir != last_dir_reg))
              state_reg <= TURN;
            else
              state_reg <= req_we ? WRITE : READ;
          end
        end
        TURN: begin
          state_reg <= we_reg ? WRITE : READ;
        end
        WRITE: begin
          last_dir_reg <= DIR_WR;
          state_reg    <= IDLE;
        end
        READ: begin
          if (cnt_reg == CNT_LAST) begin
            rsp_rdata_reg <= mem_data;
            rsp_valid_reg <= 1'b1;
            last_dir_reg  <= DIR_RD;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them (and the bus) at once
  assign mem_wen   = (state_reg == WRITE);
  assign mem_ren   = (state_reg == READ);
  assign mem_addr  = addr_reg;
  assign mem_data  = mem_wen ? wdata_reg : 'z;
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule
